// File: rtl/user_key_pkg.sv
// Purpose: shared constants and types for the push-button peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Optional feature macro: USER_KEY_RELEASE_EVENT_EN widens event/mask registers to 16 bits.
package user_key_pkg;

  localparam int NUM_KEYS      = 8;
  localparam int DB_CYCLES_DEF = 4;

  localparam logic [1:0] KEY_STATE_OFS = 2'd0;
  localparam logic [1:0] KEY_EVENT_OFS = 2'd1;
  localparam logic [1:0] IRQ_MASK_OFS  = 2'd2;

  // Width of KEY_EVENT / IRQ_MASK: press bits only, or press + release bits.
`ifdef USER_KEY_RELEASE_EVENT_EN
  localparam int EV_W = 2 * NUM_KEYS;
`else
  localparam int EV_W = NUM_KEYS;
`endif

  // Debounce state: synchronized level agrees with the accepted level, or not.
  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_e;

endpackage

// File: rtl/key_debounce.sv
// Purpose: synchronize and debounce one active-low push-button.
// Latency: a steady raw edge moves stable DB_CYCLES+2 clk_in edges later; rise/fall pulse on that same edge.
// Backpressure: none, free-running every cycle.
// Ports: clk_in/sys_rstn clock and async active-low reset; key_n raw button (0 = pressed);
//        stable debounced pressed level; rise/fall one-cycle pulses on stable 0->1 / 1->0.
// Optional feature macro: USER_KEY_RELEASE_EVENT_EN adds the fall output.
module key_debounce
  import user_key_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 8
) (
  input  logic clk_in,
  input  logic sys_rstn,
  input  logic key_n,
  output logic stable,
  output logic rise
`ifdef USER_KEY_RELEASE_EVENT_EN
  ,
  output logic fall
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             keyn_s;
  logic             pressed_s;
  logic [CNT_W-1:0] cnt;
  db_state_e        state;

  assign pressed_s = ~keyn_s;
  assign state     = (pressed_s == stable) ? DB_IDLE : DB_COUNT;

  // Sync flops reset to 1 so an idle (released) key looks released immediately.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1  <= 1'b1;
      keyn_s <= 1'b1;
    end else begin
      sync1  <= key_n;
      keyn_s <= sync1;
    end
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
`ifdef USER_KEY_RELEASE_EVENT_EN
      fall   <= 1'b0;
`endif
    end else begin
      rise <= 1'b0;
`ifdef USER_KEY_RELEASE_EVENT_EN
      fall <= 1'b0;
`endif
      case (state)
        DB_IDLE: cnt <= '0;
        DB_COUNT: begin
          // The DB_CYCLES-th consecutive mismatched cycle accepts the new level.
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= pressed_s;
            rise   <= pressed_s;
`ifdef USER_KEY_RELEASE_EVENT_EN
            fall   <= ~pressed_s;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/user_key_ctrl.sv
// Purpose: bus-slave push-button controller with sticky W1C press events and masked level irq.
// Latency: key edge -> stable at DB_CYCLES+2 edges, event bit and irq at DB_CYCLES+3 edges; reads are combinational.
// Backpressure: none, writes complete in the strobe cycle and reads never stall.
// Ports: clk_in, sys_rstn (async active-low); user_key[7:0] raw active-low buttons;
//        addr/we/wdata register write port; rdata combinational read data; irq level interrupt.
// Optional feature macro: USER_KEY_RELEASE_EVENT_EN adds release events in KEY_EVENT[15:8] and IRQ_MASK[15:8].
module user_key_ctrl
  import user_key_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 8
) (
  input  logic                clk_in,
  input  logic                sys_rstn,
  input  logic [NUM_KEYS-1:0] user_key,
  input  logic [1:0]          addr,
  input  logic                we,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                irq
);

  logic [NUM_KEYS-1:0] key_stable;
  logic [NUM_KEYS-1:0] key_rise;
`ifdef USER_KEY_RELEASE_EVENT_EN
  logic [NUM_KEYS-1:0] key_fall;
`endif

  logic [EV_W-1:0] ev_q;
  logic [EV_W-1:0] mask_q;
  logic [EV_W-1:0] ev_set;
  logic [EV_W-1:0] ev_clr;
  logic [EV_W-1:0] ev_nxt;
  logic [EV_W-1:0] mask_nxt;
  logic            unused_wdata;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk_in   (clk_in),
      .sys_rstn (sys_rstn),
      .key_n    (user_key[g]),
      .stable   (key_stable[g]),
      .rise     (key_rise[g])
`ifdef USER_KEY_RELEASE_EVENT_EN
      ,
      .fall     (key_fall[g])
`endif
    );
  end

`ifdef USER_KEY_RELEASE_EVENT_EN
  assign ev_set = {key_fall, key_rise};
`else
  assign ev_set = key_rise;
`endif

  assign ev_clr   = (we && addr == KEY_EVENT_OFS) ? wdata[EV_W-1:0] : '0;
  // Set is OR-ed after the clear so a simultaneous hardware event wins.
  assign ev_nxt   = (ev_q & ~ev_clr) | ev_set;
  assign mask_nxt = (we && addr == IRQ_MASK_OFS) ? wdata[EV_W-1:0] : mask_q;

  assign unused_wdata = ^wdata[31:EV_W];

  // irq uses next-state values so it rises on the same edge as the event bit.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      ev_q   <= '0;
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      ev_q   <= ev_nxt;
      mask_q <= mask_nxt;
      irq    <= |(ev_nxt & mask_nxt);
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      KEY_STATE_OFS: rdata = {{(32-NUM_KEYS){1'b0}}, key_stable};
      KEY_EVENT_OFS: rdata = {{(32-EV_W){1'b0}}, ev_q};
      IRQ_MASK_OFS:  rdata = {{(32-EV_W){1'b0}}, mask_q};
      default:       rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_user_key_ctrl.sv
// Purpose: self-checking bench for user_key_ctrl against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_user_key_ctrl;
  import user_key_pkg::*;

  localparam int DB = 4;

  logic        clk_in = 1'b0;
  logic        sys_rstn;
  logic [7:0]  user_key;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [7:0]      m_s1, m_s2, m_stable;
  int              m_run [8];
  logic [EV_W-1:0] m_pend, m_ev, m_mask;
  logic            m_irq;

  always #5 clk_in = ~clk_in;

  user_key_ctrl #(.DB_CYCLES(DB), .CNT_W(8)) dut (
    .clk_in   (clk_in),
    .sys_rstn (sys_rstn),
    .user_key (user_key),
    .addr     (addr),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 8'hFF; m_s2 = 8'hFF; m_stable = '0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
    m_pend = '0; m_ev = '0; m_mask = '0; m_irq = 1'b0;
  endtask

  // One clock edge: a key is accepted after DB consecutive synchronized samples
  // disagreeing with the accepted level; the resulting event lands one edge later.
  task automatic model_step();
    logic [7:0]      p;
    logic [EV_W-1:0] newpend, clr;
    p = ~m_s2;
    newpend = '0;
    for (int i = 0; i < 8; i++) begin
      if (p[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_stable[i] = p[i];
          m_run[i] = 0;
          if (p[i]) newpend[i] = 1'b1;
`ifdef USER_KEY_RELEASE_EVENT_EN
          else newpend[i+8] = 1'b1;
`endif
        end
      end else begin
        m_run[i] = 0;
      end
    end
    clr    = (we && addr == 2'd1) ? wdata[EV_W-1:0] : '0;
    m_ev   = (m_ev & ~clr) | m_pend;
    m_pend = newpend;
    if (we && addr == 2'd2) m_mask = wdata[EV_W-1:0];
    m_irq  = |(m_ev & m_mask);
    m_s2   = m_s1;
    m_s1   = user_key;
  endtask

  function automatic logic [31:0] model_rdata(input int a);
    case (a)
      0:       return {24'b0, m_stable};
      1:       return {{(32-EV_W){1'b0}}, m_ev};
      2:       return {{(32-EV_W){1'b0}}, m_mask};
      default: return 32'b0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic [1:0] saved;
    saved = addr;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check($sformatf("%s_rd%0d", tag, a), rdata, model_rdata(a));
    end
    check($sformatf("%s_irq", tag), {31'b0, irq}, {31'b0, m_irq});
    addr = saved;
  endtask

  task automatic step(input string tag);
    @(posedge clk_in);
    if (sys_rstn) model_step();
    else model_reset();
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic wr(input string tag, input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step(tag);
    we = 1'b0; wdata = '0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [1:0] saved;
    saved = addr;
    addr = a;
    #1;
    check(tag, rdata, exp);
    addr = saved;
  endtask

  initial begin
    sys_rstn = 1'b0; user_key = 8'hFF; addr = '0; we = 1'b0; wdata = '0;
    model_reset();

    // Reset
    steps("rst", 3);
    sys_rstn = 1'b1;
    check_all("rst_rel");

    // Clean press on key 0
    wr("mask1", 2'd2, 32'h1);
    user_key = 8'hFE;
    steps("press", 5);
    rd_check("press_ev_early", 2'd1, 32'h0);
    user_key = 8'hFF;
    step("press6");
    rd_check("press_state", 2'd0, 32'h1);
    step("press7");
    rd_check("press_ev", 2'd1, 32'h1);
    check("press_irq", {31'b0, irq}, 32'h1);
    steps("press_rel", 10);
    rd_check("press_state_back", 2'd0, 32'h0);

    // Glitch shorter than the debounce window
    wr("clr_all", 2'd1, 32'hFFFF);
    user_key = 8'hFD;
    steps("glitch", 2);
    user_key = 8'hFF;
    steps("glitch_post", 8);
    rd_check("glitch_ev", 2'd1, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);

    // Set/clear collision on key 0
    user_key = 8'hFE;
    steps("coll_a", DB + 3);
    user_key = 8'hFF;
    steps("coll_b", 12);
    rd_check("coll_pending", 2'd1, 32'h1);
    user_key = 8'hFE;
    steps("coll_c", DB + 2);
    wr("coll_w1c", 2'd1, 32'h1);
    rd_check("coll_setwins", 2'd1, 32'h1);
    wr("coll_clr", 2'd1, 32'h1);
    rd_check("coll_cleared", 2'd1, 32'h0);
    user_key = 8'hFF;
    steps("coll_d", 12);

    // Mask gating with keys 1 and 7 held
    wr("mg_clr", 2'd1, 32'hFFFF);
    wr("mg_mask0", 2'd2, 32'h0);
    user_key = 8'h7D;
    steps("mg_press", DB + 3);
    rd_check("mg_ev", 2'd1, 32'h82);
    check("mg_irq0", {31'b0, irq}, 32'h0);
    wr("mg_mask80", 2'd2, 32'h80);
    check("mg_irq1", {31'b0, irq}, 32'h1);
    wr("mg_clr80", 2'd1, 32'h80);
    check("mg_irq2", {31'b0, irq}, 32'h0);
    rd_check("mg_ev2", 2'd1, 32'h02);
    user_key = 8'hFF;
    steps("mg_rel", 12);

    // Reset in the middle of a key 3 press
    wr("rm_clr", 2'd1, 32'hFFFF);
    wr("rm_mask", 2'd2, 32'hFFFF);
    user_key = 8'hF7;
    steps("rm_count", 2);
    sys_rstn = 1'b0;
    model_reset();
    check_all("rm_async");
    steps("rm_hold", 2);
    sys_rstn = 1'b1;
    steps("rm_redb", DB + 2);
    rd_check("rm_ev_early", 2'd1, 32'h0);
    step("rm_ev_step");
    rd_check("rm_ev", 2'd1, 32'h08);
    wr("rm_mask8", 2'd2, 32'h0808);
    user_key = 8'hFF;
    steps("rm_rel", 12);
`ifdef USER_KEY_RELEASE_EVENT_EN
    rd_check("rm_rel_ev", 2'd1, 32'h0808);
`else
    rd_check("rm_rel_ev", 2'd1, 32'h08);
`endif

    // Randomized key activity and register traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(5, 0) == 0) user_key[$urandom_range(7, 0)] ^= 1'b1;
      if ($urandom_range(11, 0) == 0) begin
        addr = 2'($urandom_range(3, 0));
        wdata = $urandom;
        we = 1'b1;
      end
      step("rand");
      we = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
